comparator_pipe: RTL
====================

# comparator_pipe

Parametrised, streaming magnitude comparator for the datapath test blocks. It accepts operand pairs A/B of WIDTH bits over a valid/ready handshake, with a per-transaction signed/unsigned mode. It returns one-hot greater/equal/less flags and the full-precision difference through a two-stage back-pressurable pipeline. Saturating per-class event counters let a host read result statistics without sampling every output.

## Interface
- WIDTH, 16: operand width in bits; must be ≥ 2.
- CNT_W, 16: width of each statistics counter; must be ≥ 1.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand pair offered
- in_ready  out  1  block can accept an operand pair this cycle
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- in_signed  in  1  1: two's-complement compare; 0: unsigned
- out_valid  out  1  result held on out_*
- out_ready  in  1  consumer accepts the result
- out_gt / out_eq / out_lt  out  1 each  one-hot compare result (A>B, A==B, A<B)
- out_diff  out  WIDTH+1  A−B as a two's-complement value
- clr_cnt  in  1  synchronous clear of all counters
- cnt_gt / cnt_eq / cnt_lt  out  CNT_W each  saturating counts of delivered results

## Operation
- Pipeline: S1 registers in_a, in_b, in_signed. S2 registers the compare result. Each stage holds a valid bit.
- Arithmetic: extend both operands to WIDTH+1 bits (sign-extend if in_signed, else zero-extend), then diff = ext(A) − ext(B) mod 2^(WIDTH+1).
- Flags from diff: lt = diff[WIDTH]; eq = (diff == 0); gt = !lt && !eq. Exactly one flag is high whenever out_valid = 1. No overflow is possible at WIDTH+1 bits.
- Handshake: a transfer occurs on an edge where valid && ready.
  - Stage Sn loads when it is empty or its content leaves this edge.
  - in_ready = !S1.valid || (S1 moves into S2 this edge).
  - S2 content leaves when out_ready = 1.
- out_* are stable while out_valid && !out_ready. in_* are ignored when in_ready = 0.
- Full throughput: one transaction per cycle when out_ready stays high. Order is strictly preserved. No transaction is dropped or duplicated.
- Counters: on each output transfer, the counter matching the delivered flag increments. It saturates at 2^CNT_W − 1 and does not wrap.
- clr_cnt: all counters go to 0 on the next edge. If an output transfer happens on the same edge, the matching counter loads 1 and the other two load 0.
- Reset (any time, including mid-stream): both valid bits clear and all in-flight data is discarded. Reset values:
  - in_ready = 1 (combinational, so it is 1 during reset).
  - out_valid = 0, out_gt = out_eq = out_lt = 0, out_diff = 0.
  - cnt_* = 0.

## Timing
- Pair accepted on edge k appears on out_* immediately after edge k+1 when S2 is free (latency 2 edges).
- in_ready is the only combinational path (depends on out_ready). All other outputs are registered.
- With out_ready held low, at most 2 transactions are absorbed (S1 + S2). in_ready then drops in the same cycle the second is accepted... precisely: in_ready = 0 from the cycle after both stages are valid until out_ready rises. When out_ready rises, in_ready rises in the same cycle.
- cnt_* update on the same edge as the output transfer and are visible the following cycle.

## Structure
- Package cmp_pkg:
  - cmp_flags_t: packed struct {gt, eq, lt}.
  - Localparam helper for the WIDTH+1 diff width.
  - Counter saturation constant function.
- One sub-module, cmp_pipe_slot: a parametric data register plus valid bit with load/drain ports, instantiated twice (S1 payload = 2·WIDTH+1 bits, S2 payload = WIDTH+1+3 bits).
- The compare logic and counters stay in the top module.

## Test plan
All cases use WIDTH = 8.
- Unsigned vs signed: in_a = 8'hF0, in_b = 8'h0F.
  - in_signed = 0 → gt, out_diff = 9'h0E1 (+225).
  - in_signed = 1 → lt, out_diff = 9'h1E1 (−31).
- Extremes: A = 8'h80, B = 8'h7F, signed → lt, diff = 9'h101 (−255). Unsigned → gt, diff = 9'h001. A = B = 8'h80 → eq, diff = 0 in both modes.
- Back-pressure:
  - Hold out_ready = 0 and offer 4 back-to-back pairs. Exactly 2 are accepted, and in_ready = 0 thereafter.
  - Raise out_ready. All 4 results arrive in order with no gaps.
  - out_* stay stable while stalled.
- Throughput: 100 random pairs with out_ready = 1 and in_valid = 1 → 100 results in 101 cycles, each matching the reference model.
- Counters, CNT_W = 2:
  - 5 gt transfers → cnt_gt = 3 (saturated).
  - clr_cnt on the same edge as an eq transfer → cnt_eq = 1, cnt_gt = cnt_lt = 0.
- Reset mid-stream: assert rst_n = 0 with both stages valid → out_valid and cnt_* are 0 immediately, without waiting for an edge. After release, the first new pair has latency 2 and no stale result appears.

Source files
------------

// File: rtl/cmp_pkg.sv
// Shared types and sizing helpers for the streaming magnitude comparator.
package cmp_pkg;

    typedef struct packed {
        logic gt;
        logic eq;
        logic lt;
    } cmp_flags_t;

    localparam int unsigned FlagsW = 3;

    // One extra bit makes the A-B difference exact for both signed and unsigned operands.
    function automatic int unsigned diff_width(input int unsigned width);
        return width + 1;
    endfunction

    function automatic logic [63:0] cnt_sat(input int unsigned cnt_w);
        return (cnt_w >= 64) ? '1 : ((64'd1 << cnt_w) - 64'd1);
    endfunction

endpackage

// File: rtl/cmp_pipe_slot.sv
// One pipeline stage: payload register plus valid bit; load wins over drain.
module cmp_pipe_slot #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic         drain_i,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (drain_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/comparator_pipe.sv
// Two-stage valid/ready magnitude comparator with signed/unsigned mode and
// saturating per-result statistics counters.
module comparator_pipe
    import cmp_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic               in_signed,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_gt,
    output logic               out_eq,
    output logic               out_lt,
    output logic [WIDTH:0]     out_diff,
    input  logic               clr_cnt,
    output logic [CNT_W-1:0]   cnt_gt,
    output logic [CNT_W-1:0]   cnt_eq,
    output logic [CNT_W-1:0]   cnt_lt
);

    localparam int unsigned DiffW = diff_width(WIDTH);
    localparam int unsigned S1W   = 2 * WIDTH + 1;
    localparam int unsigned S2W   = DiffW + FlagsW;
    localparam logic [CNT_W-1:0] CntMax = CNT_W'(cnt_sat(CNT_W));
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    logic             s1_valid, s2_valid;
    logic             s1_move, in_fire, out_fire;
    logic [S1W-1:0]   s1_data;
    logic [S2W-1:0]   s2_data_in, s2_data;
    logic [WIDTH-1:0] s1_a, s1_b;
    logic             s1_signed;
    logic [DiffW-1:0] ext_a, ext_b, diff;
    cmp_flags_t       flags, out_flags;

    // S1 may advance when S2 is empty or is being drained on this edge.
    assign s1_move  = s1_valid && (!s2_valid || out_ready);
    assign in_ready = !s1_valid || s1_move;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = s2_valid && out_ready;

    cmp_pipe_slot #(.W(S1W)) u_s1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (in_fire),
        .drain_i (s1_move),
        .data_i  ({in_a, in_b, in_signed}),
        .valid_o (s1_valid),
        .data_o  (s1_data)
    );

    assign {s1_a, s1_b, s1_signed} = s1_data;
    assign ext_a = {s1_signed & s1_a[WIDTH-1], s1_a};
    assign ext_b = {s1_signed & s1_b[WIDTH-1], s1_b};
    assign diff  = ext_a - ext_b;

    always_comb begin
        flags.lt = diff[WIDTH];
        flags.eq = (diff == '0);
        flags.gt = !flags.lt && !flags.eq;
    end

    assign s2_data_in = {diff, flags};

    cmp_pipe_slot #(.W(S2W)) u_s2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (s1_move),
        .drain_i (out_fire),
        .data_i  (s2_data_in),
        .valid_o (s2_valid),
        .data_o  (s2_data)
    );

    assign {out_diff, out_flags} = s2_data;
    assign out_valid = s2_valid;
    assign out_gt    = out_flags.gt;
    assign out_eq    = out_flags.eq;
    assign out_lt    = out_flags.lt;

    // Index 2/1/0 = gt/eq/lt.
    logic [2:0]            hit;
    logic [2:0][CNT_W-1:0] cnt_q, cnt_d;

    assign hit = {out_flags.gt, out_flags.eq, out_flags.lt} & {3{out_fire}};

    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < 3; i++) begin
            if (clr_cnt) begin
                cnt_d[i] = hit[i] ? CntOne : '0;
            end else if (hit[i] && (cnt_q[i] != CntMax)) begin
                cnt_d[i] = cnt_q[i] + CntOne;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_gt = cnt_q[2];
    assign cnt_eq = cnt_q[1];
    assign cnt_lt = cnt_q[0];

endmodule
